// File: rtl/pdm_ramp_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : pdm_ramp_ctrl
// Brief    : MCS IO-bus register block that ramps per-channel PDM duty words
//            toward programmable targets at a prescaled step rate.
// Revision : 1.0 - initial release
// =============================================================================
module pdm_ramp_ctrl #(
    parameter int DUTY_BITS  = 8,
    parameter int CH_COUNT   = 2,
    parameter int PRESC_BITS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          io_addr_strobe,
    input  logic                          io_read_strobe,
    input  logic                          io_write_strobe,
    input  logic [11:0]                   io_address,
    input  logic [31:0]                   io_write_data,
    output logic [31:0]                   io_read_data,
    output logic                          io_ready,
    output logic [CH_COUNT-1:0]           pdm_en,
    output logic [CH_COUNT*DUTY_BITS-1:0] pdm_duty,
    output logic                          irq
);
    localparam int c_idx_w = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(CH_COUNT - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t                r_state, w_state_nxt;
    logic [c_idx_w-1:0]    r_idx, w_idx_nxt;
    logic                  r_scan_pend, w_scan_pend_nxt;

    logic [CH_COUNT-1:0]   r_en, r_irq_en, r_irq_pend;
    logic [PRESC_BITS-1:0] r_presc, r_presc_cnt;
    logic [DUTY_BITS-1:0]  r_tgt  [CH_COUNT];
    logic [DUTY_BITS-1:0]  r_step [CH_COUNT];
    logic [DUTY_BITS-1:0]  r_cur  [CH_COUNT];
    logic                  r_ready;
    logic [31:0]           r_rdata;

    logic                  w_wr, w_rd, w_tick, w_unused;
    logic                  w_wr_ctrl, w_wr_presc, w_wr_pend;
    logic [CH_COUNT-1:0]   w_wr_tgt, w_wr_step, w_wr_cur, w_upd, w_set, w_busy;
    logic [DUTY_BITS-1:0]  w_new [CH_COUNT];
    logic [31:0]           w_rdata;

    // One extra bit on the sum/difference lets overshoot and underflow be seen and clamped.
    function automatic logic [DUTY_BITS-1:0] ramp_step(input logic [DUTY_BITS-1:0] cur,
                                                       input logic [DUTY_BITS-1:0] tgt,
                                                       input logic [DUTY_BITS-1:0] step);
        logic [DUTY_BITS:0] sum;
        logic [DUTY_BITS:0] dif;
        sum = {1'b0, cur} + {1'b0, step};
        dif = {1'b0, cur} - {1'b0, step};
        if (step == '0)
            return tgt;
        if (cur < tgt)
            return (sum > {1'b0, tgt}) ? tgt : sum[DUTY_BITS-1:0];
        if (cur > tgt)
            return (dif[DUTY_BITS] || (dif[DUTY_BITS-1:0] < tgt)) ? tgt : dif[DUTY_BITS-1:0];
        return cur;
    endfunction

    assign w_wr       = io_addr_strobe & io_write_strobe;
    assign w_rd       = io_addr_strobe & io_read_strobe;
    assign w_tick     = (r_presc_cnt >= r_presc);
    assign w_wr_ctrl  = w_wr && (io_address == 12'h000);
    assign w_wr_presc = w_wr && (io_address == 12'h004);
    assign w_wr_pend  = w_wr && (io_address == 12'h00C);
    assign w_unused   = ^io_write_data;

    always_comb begin
        for (int n = 0; n < CH_COUNT; n++) begin
            w_wr_tgt[n]  = w_wr && (io_address == 12'(16 * n + 16));
            w_wr_step[n] = w_wr && (io_address == 12'(16 * n + 20));
            w_wr_cur[n]  = w_wr && (io_address == 12'(16 * n + 24));
            w_busy[n]    = (r_cur[n] != r_tgt[n]);
            w_new[n]     = ramp_step(r_cur[n], r_tgt[n], r_step[n]);
            // A bus write to this channel's target or current value overrides the ramp step.
            w_upd[n]     = (r_state == SCAN) && (r_idx == c_idx_w'(n)) && r_en[n]
                           && !w_wr_tgt[n] && !w_wr_cur[n];
            w_set[n]     = w_upd[n] && w_busy[n] && (w_new[n] == r_tgt[n]);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (io_address)
            12'h000: begin
                w_rdata[CH_COUNT-1:0] = r_en;
                w_rdata[8 +: CH_COUNT] = r_irq_en;
            end
            12'h004: w_rdata[PRESC_BITS-1:0] = r_presc;
            12'h008: w_rdata[CH_COUNT-1:0]   = w_busy;
            12'h00C: w_rdata[CH_COUNT-1:0]   = r_irq_pend;
            default: ;
        endcase
        for (int n = 0; n < CH_COUNT; n++) begin
            if (io_address == 12'(16 * n + 16)) w_rdata[DUTY_BITS-1:0] = r_tgt[n];
            if (io_address == 12'(16 * n + 20)) w_rdata[DUTY_BITS-1:0] = r_step[n];
            if (io_address == 12'(16 * n + 24)) w_rdata[DUTY_BITS-1:0] = r_cur[n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en        <= '0;
            r_irq_en    <= '0;
            r_irq_pend  <= '0;
            r_presc     <= '0;
            r_presc_cnt <= '0;
            r_ready     <= 1'b0;
            r_rdata     <= '0;
            for (int n = 0; n < CH_COUNT; n++) begin
                r_tgt[n]  <= '0;
                r_step[n] <= '0;
                r_cur[n]  <= '0;
            end
        end else begin
            r_ready     <= io_addr_strobe;
            r_rdata     <= w_rd ? w_rdata : '0;
            r_presc_cnt <= w_tick ? '0 : r_presc_cnt + 1'b1;
            if (w_wr_ctrl) begin
                r_en     <= io_write_data[CH_COUNT-1:0];
                r_irq_en <= io_write_data[8 +: CH_COUNT];
            end
            if (w_wr_presc)
                r_presc <= io_write_data[PRESC_BITS-1:0];
            r_irq_pend <= (r_irq_pend & ~(w_wr_pend ? io_write_data[CH_COUNT-1:0] : '0)) | w_set;
            for (int n = 0; n < CH_COUNT; n++) begin
                if (w_wr_tgt[n])  r_tgt[n]  <= io_write_data[DUTY_BITS-1:0];
                if (w_wr_step[n]) r_step[n] <= io_write_data[DUTY_BITS-1:0];
                if (w_wr_cur[n])
                    r_cur[n] <= io_write_data[DUTY_BITS-1:0];
                else if (w_upd[n])
                    r_cur[n] <= w_new[n];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_scan_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_scan_pend <= w_scan_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_scan_pend_nxt = r_scan_pend;
        case (r_state)
            IDLE: begin
                if (w_tick || r_scan_pend) begin
                    w_state_nxt     = SCAN;
                    w_idx_nxt       = '0;
                    w_scan_pend_nxt = 1'b0;
                end
            end
            SCAN: begin
                if (w_tick)
                    w_scan_pend_nxt = 1'b1;
                if (r_idx == c_last_idx) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign io_ready     = r_ready;
    assign io_read_data = r_rdata;
    assign pdm_en       = r_en;
    assign irq          = |(r_irq_pend & r_irq_en);

    generate
        for (genvar n = 0; n < CH_COUNT; n++) begin : g_duty
            assign pdm_duty[n*DUTY_BITS +: DUTY_BITS] = r_cur[n];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pdm_ramp_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_pdm_ramp_ctrl
// Brief    : Bench for pdm_ramp_ctrl - cycle-level reference model with a
//            per-cycle compare, directed ramp scenarios and random bus traffic.
// Revision : 1.0 - initial release
// =============================================================================
module tb_pdm_ramp_ctrl;
    localparam int DB = 8;
    localparam int CH = 2;
    localparam int PB = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             io_addr_strobe = 1'b0;
    logic             io_read_strobe = 1'b0;
    logic             io_write_strobe = 1'b0;
    logic [11:0]      io_address = '0;
    logic [31:0]      io_write_data = '0;
    logic [31:0]      io_read_data;
    logic             io_ready;
    logic [CH-1:0]    pdm_en;
    logic [CH*DB-1:0] pdm_duty;
    logic             irq;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pdm_ramp_ctrl #(.DUTY_BITS(DB), .CH_COUNT(CH), .PRESC_BITS(PB)) dut (
        .clk(clk), .rst(rst),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_address(io_address),
        .io_write_data(io_write_data), .io_read_data(io_read_data),
        .io_ready(io_ready), .pdm_en(pdm_en), .pdm_duty(pdm_duty), .irq(irq)
    );

    // Reference model state: plain integers, scan position -1 when not scanning.
    int          m_en = 0, m_ien = 0, m_pend = 0, m_presc = 0, m_cnt = 0;
    int          m_pos = -1, m_flag = 0, m_ready = 0;
    logic [31:0] m_rdata = '0;
    int          m_tgt[CH], m_step[CH], m_cur[CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ramp(input int c, input int t, input int s);
        if (s == 0) return t;
        if (c < t)  return (c + s > t) ? t : c + s;
        if (c > t)  return (c - s < t) ? t : c - s;
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [31:0] r;
        r = '0;
        if (a == 12'h000) r = 32'(m_en | (m_ien << 8));
        else if (a == 12'h004) r = 32'(m_presc);
        else if (a == 12'h008) begin
            for (int n = 0; n < CH; n++) if (m_cur[n] != m_tgt[n]) r[n] = 1'b1;
        end
        else if (a == 12'h00C) r = 32'(m_pend);
        else begin
            for (int n = 0; n < CH; n++) begin
                if (a == 12'(16 * n + 16)) r = 32'(m_tgt[n]);
                if (a == 12'(16 * n + 20)) r = 32'(m_step[n]);
                if (a == 12'(16 * n + 24)) r = 32'(m_cur[n]);
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin : p_model
        int          tick, setm, w1c, n, nc;
        logic        wr;
        logic [31:0] d;
        if (rst) begin
            m_en = 0; m_ien = 0; m_pend = 0; m_presc = 0; m_cnt = 0;
            m_pos = -1; m_flag = 0; m_ready = 0; m_rdata = '0;
            for (int k = 0; k < CH; k++) begin
                m_tgt[k] = 0; m_step[k] = 0; m_cur[k] = 0;
            end
        end else begin
            wr      = io_addr_strobe && io_write_strobe;
            d       = io_write_data;
            m_ready = int'(io_addr_strobe);
            m_rdata = (io_addr_strobe && io_read_strobe) ? m_read(io_address) : 32'h0;
            tick    = (m_cnt >= m_presc) ? 1 : 0;
            setm    = 0;
            w1c     = 0;
            if (m_pos >= 0) begin
                n = m_pos;
                if (((m_en >> n) & 1) == 1 &&
                    !(wr && (io_address == 12'(16 * n + 16) || io_address == 12'(16 * n + 24)))) begin
                    nc = ramp(m_cur[n], m_tgt[n], m_step[n]);
                    if (m_cur[n] != m_tgt[n] && nc == m_tgt[n]) setm = 1 << n;
                    m_cur[n] = nc;
                end
            end
            if (wr) begin
                if (io_address == 12'h000) begin
                    m_en  = int'(d[CH-1:0]);
                    m_ien = int'(d[8 +: CH]);
                end
                if (io_address == 12'h004) m_presc = int'(d[PB-1:0]);
                if (io_address == 12'h00C) w1c = int'(d[CH-1:0]);
                for (int k = 0; k < CH; k++) begin
                    if (io_address == 12'(16 * k + 16)) m_tgt[k]  = int'(d[DB-1:0]);
                    if (io_address == 12'(16 * k + 20)) m_step[k] = int'(d[DB-1:0]);
                    if (io_address == 12'(16 * k + 24)) m_cur[k]  = int'(d[DB-1:0]);
                end
            end
            m_pend = (m_pend & ~w1c) | setm;
            m_cnt  = (tick != 0) ? 0 : m_cnt + 1;
            if (m_pos < 0) begin
                if (tick != 0 || m_flag != 0) begin
                    m_pos  = 0;
                    m_flag = 0;
                end
            end else begin
                if (tick != 0) m_flag = 1;
                m_pos = (m_pos == CH - 1) ? -1 : m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin : p_compare
        logic [CH*DB-1:0] ed;
        for (int k = 0; k < CH; k++) ed[k*DB +: DB] = DB'(m_cur[k]);
        check("io_ready", 32'(io_ready), 32'(m_ready));
        check("io_read_data", io_read_data, m_rdata);
        check("pdm_en", 32'(pdm_en), 32'(m_en));
        check("pdm_duty", 32'(pdm_duty), 32'(ed));
        check("irq", 32'(irq), ((m_pend & m_ien) != 0) ? 32'd1 : 32'd0);
    end

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        io_addr_strobe = 1'b1; io_write_strobe = 1'b1;
        io_address = a; io_write_data = d;
        @(negedge clk);
        io_addr_strobe = 1'b0; io_write_strobe = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        io_addr_strobe = 1'b1; io_read_strobe = 1'b1; io_address = a;
        @(negedge clk);
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0;
        check("read ready", 32'(io_ready), 32'd1);
        d = io_read_data;
    endtask

    function automatic int duty(input int ch);
        return int'(pdm_duty[ch*DB +: DB]);
    endfunction

    task automatic track(input int ch, input int n, input int exp[8], input int spacing,
                         input string tag);
        int prev, v, k, cyc, last;
        prev = duty(ch); k = 0; cyc = 0; last = -1;
        while (k < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            v = duty(ch);
            if (v != prev) begin
                check({tag, " value"}, 32'(v), 32'(exp[k]));
                if (spacing > 0 && last >= 0) check({tag, " spacing"}, 32'(cyc - last), 32'(spacing));
                last = cyc; prev = v; k++;
            end
        end
        check({tag, " steps seen"}, 32'(k), 32'(n));
        repeat (20) @(negedge clk);
        check({tag, " settled"}, 32'(duty(ch)), 32'(exp[n-1]));
    endtask

    logic [11:0] addr_tab[13] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                                  12'h018, 12'h020, 12'h024, 12'h028, 12'h030, 12'h100, 12'h002};

    initial begin : p_stim
        logic [31:0] rd, d;
        int          ex[8];
        int          prev, cnt, found;
        logic [11:0] a;
        int          op;

        repeat (2) @(negedge clk);
        check("reset duty", 32'(pdm_duty), 32'd0);
        check("reset en", 32'(pdm_en), 32'd0);
        check("reset irq", 32'(irq), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        bus_write(12'h004, 32'hABCD_1234);
        bus_read(12'h004, rd);
        check("presc readback", rd, 32'h0000_1234);
        bus_read(12'h100, rd);
        check("unmapped read", rd, 32'h0);
        @(negedge clk);
        check("ready one cycle", 32'(io_ready), 32'd0);

        bus_write(12'h004, 32'd3);
        bus_write(12'h014, 32'd16);
        bus_write(12'h010, 32'd100);
        bus_write(12'h000, 32'h101);
        ex = '{16, 32, 48, 64, 80, 96, 100, 0};
        track(0, 7, ex, 4, "ramp up");
        check("irq after ramp", 32'(irq), 32'd1);
        bus_read(12'h00C, rd);
        check("pend after ramp", rd, 32'd1);
        bus_write(12'h00C, 32'd1);
        check("irq cleared", 32'(irq), 32'd0);

        bus_write(12'h000, 32'h100);
        bus_write(12'h018, 32'd200);
        bus_write(12'h010, 32'd5);
        bus_write(12'h014, 32'd64);
        bus_write(12'h000, 32'h101);
        ex = '{136, 72, 8, 5, 0, 0, 0, 0};
        track(0, 4, ex, 4, "ramp down");
        check("irq after down", 32'(irq), 32'd1);
        bus_write(12'h00C, 32'd1);

        bus_write(12'h000, 32'h100);
        bus_write(12'h018, 32'd10);
        bus_write(12'h010, 32'd250);
        bus_write(12'h014, 32'd0);
        bus_write(12'h000, 32'h101);
        ex = '{250, 0, 0, 0, 0, 0, 0, 0};
        track(0, 1, ex, 0, "step zero");
        bus_write(12'h00C, 32'd1);

        bus_write(12'h000, 32'h0);
        bus_write(12'h018, 32'd0);
        bus_write(12'h010, 32'd5);
        bus_write(12'h014, 32'd1);
        bus_write(12'h028, 32'd0);
        bus_write(12'h020, 32'd3);
        bus_write(12'h024, 32'd1);
        bus_write(12'h004, 32'd0);
        bus_write(12'h000, 32'h3);
        ex = '{1, 2, 3, 4, 5, 0, 0, 0};
        track(0, 5, ex, 3, "presc zero");
        bus_read(12'h00C, rd);
        check("pend both", rd, 32'd3);
        bus_write(12'h00C, 32'd3);

        // Land a TARGET_1 write exactly on channel 1's scan slot (scan period is 3 cycles here).
        bus_write(12'h020, 32'd200);
        bus_write(12'h028, 32'd0);
        prev = duty(1); cnt = 0; found = 0;
        while (found == 0 && cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (duty(1) != prev) found = 1;
        end
        check("ch1 moving", 32'(found), 32'd1);
        repeat (2) @(negedge clk);
        prev = duty(1);
        bus_write(12'h020, 32'd77);
        check("collision cur held", 32'(duty(1)), 32'(prev));
        bus_read(12'h020, rd);
        check("collision target kept", rd, 32'd77);

        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst duty", 32'(pdm_duty), 32'd0);
        check("async rst en", 32'(pdm_en), 32'd0);
        check("async rst irq", 32'(irq), 32'd0);
        check("async rst ready", 32'(io_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_read(12'h020, rd);
        check("target after rst", rd, 32'd0);
        bus_read(12'h000, rd);
        check("ctrl after rst", rd, 32'd0);

        for (int i = 0; i < 700; i++) begin
            a  = addr_tab[$urandom_range(0, 12)];
            op = $urandom_range(0, 9);
            if (op < 4) begin
                d = $urandom;
                if (a == 12'h004) d = $urandom_range(0, 5);
                if (a == 12'h014 || a == 12'h024) d = $urandom_range(0, 40);
                bus_write(a, d);
            end else if (op < 7) begin
                bus_read(a, rd);
            end else if (op == 7) begin
                io_addr_strobe = 1'b1; io_address = a;
                @(negedge clk);
                io_addr_strobe = 1'b0;
            end else begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
